// File: rtl/prim_util_pkg.sv
// rtl/prim_util_pkg.sv - shared utility functions
package prim_util_pkg;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/prim_count.sv
// rtl/prim_count.sv - hardened up/down counter with an inverted shadow copy
module prim_count #(
    parameter int               Width      = 3,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,      // clock
    input  logic             rst_ni,     // async reset, active low
    input  logic             incr_en_i,  // add step_i this cycle
    input  logic             decr_en_i,  // subtract step_i this cycle
    input  logic [Width-1:0] step_i,     // increment/decrement amount
    input  logic             set_i,      // load set_cnt_i, overrides incr/decr
    input  logic [Width-1:0] set_cnt_i,  // value loaded on set_i
    input  logic             commit_i,   // allow incr/decr to update the count
    output logic [Width-1:0] cnt_o,      // current count
    output logic             err_o       // primary and shadow copies disagree
);

    logic [Width-1:0] r_cnt;
    logic [Width-1:0] r_cnt_inv;
    logic [Width-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (set_i) begin
            w_cnt_d = set_cnt_i;
        end else if (commit_i) begin
            w_cnt_d = r_cnt + (incr_en_i ? step_i : '0) - (decr_en_i ? step_i : '0);
        end
    end

    // The shadow holds the bitwise inverse so a single stuck or flipped bit
    // in either copy shows up as a mismatch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= ResetValue;
            r_cnt_inv <= ~ResetValue;
        end else begin
            r_cnt     <= w_cnt_d;
            r_cnt_inv <= ~w_cnt_d;
        end
    end

    assign cnt_o = r_cnt;
    assign err_o = (r_cnt != ~r_cnt_inv);

endmodule

// File: rtl/prim_fifo_credit_tx.sv
// rtl/prim_fifo_credit_tx.sv - credit-based transmit side into a remote FIFO
module prim_fifo_credit_tx
    import prim_util_pkg::*;
#(
    parameter int Width  = 8,
    parameter int Depth  = 4,
    parameter bit Secure = 1'b0,
    localparam int DepthW = vbits(Depth + 1)
) (
    input  logic              clk_i,          // clock
    input  logic              rst_ni,         // async reset, active low
    input  logic              clr_i,          // sync clear, paired with remote FIFO clear
    input  logic              valid_i,        // upstream word valid
    output logic              ready_o,        // upstream may transfer
    input  logic [Width-1:0]  data_i,         // upstream word
    output logic              tx_valid_o,     // remote FIFO write strobe
    output logic [Width-1:0]  tx_data_o,      // remote FIFO write data
    input  logic              credit_i,       // remote popped one entry
    output logic [DepthW-1:0] credits_o,      // credits held, 0..Depth
    output logic [DepthW-1:0] outstanding_o,  // entries believed occupied remotely
    output logic              idle_o,         // all credits home, nothing in flight
    output logic              err_o           // sticky protocol/integrity error
);

    localparam logic [DepthW-1:0] DepthVal = DepthW'(Depth);

    logic [DepthW-1:0] w_credits;
    logic [DepthW:0]   w_credits_d;
    logic              w_send;
    logic              w_ovf;
    logic              w_cnt_err;

    logic              r_tx_valid;
    logic [Width-1:0]  r_tx_data;
    logic              r_err;

    assign ready_o = (w_credits != '0);
    // A clear discards whatever the upstream handshake offered this cycle.
    assign w_send  = valid_i & ready_o & ~clr_i;

    // One extra bit so a return at full credit is visible as Depth+1.
    assign w_credits_d = {1'b0, w_credits} - {{DepthW{1'b0}}, w_send}
                       + {{DepthW{1'b0}}, credit_i};
    assign w_ovf       = ~clr_i & (w_credits_d > {1'b0, DepthVal});

    if (Secure) begin : gen_secure_cnt
        // The overflowing return is dropped so the count saturates at Depth.
        prim_count #(
            .Width      (DepthW),
            .ResetValue (DepthVal)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .incr_en_i (credit_i & ~w_ovf),
            .decr_en_i (w_send),
            .step_i    (DepthW'(1)),
            .set_i     (clr_i),
            .set_cnt_i (DepthVal),
            .commit_i  (1'b1),
            .cnt_o     (w_credits),
            .err_o     (w_cnt_err)
        );
    end else begin : gen_normal_cnt
        logic [DepthW-1:0] r_credits;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_credits <= DepthVal;
            end else if (clr_i) begin
                r_credits <= DepthVal;
            end else if (!w_ovf) begin
                r_credits <= w_credits_d[DepthW-1:0];
            end
        end

        assign w_credits = r_credits;
        assign w_cnt_err = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_tx_valid <= w_send;
            if (w_send) begin
                r_tx_data <= data_i;
            end
            // Survives clr_i; only reset clears it.
            r_err <= r_err | w_ovf | w_cnt_err;
        end
    end

    assign tx_valid_o    = r_tx_valid;
    assign tx_data_o     = r_tx_data;
    assign credits_o     = w_credits;
    assign outstanding_o = DepthVal - w_credits;
    assign idle_o        = (w_credits == DepthVal) & ~r_tx_valid;
    assign err_o         = r_err;

endmodule

// File: tb/tb_prim_fifo_credit_tx.sv
// tb/tb_prim_fifo_credit_tx.sv - directed bench for both counter variants
module tb_prim_fifo_credit_tx;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clr_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       credit_i;

    logic       ready0, tx_valid0, idle0, err0;
    logic [7:0] tx_data0;
    logic [2:0] credits0, outst0;
    logic       ready1, tx_valid1, idle1, err1;
    logic [7:0] tx_data1;
    logic [2:0] credits1, outst1;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    prim_fifo_credit_tx #(.Width(8), .Depth(4), .Secure(1'b0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .valid_i(valid_i),
        .ready_o(ready0), .data_i(data_i), .tx_valid_o(tx_valid0),
        .tx_data_o(tx_data0), .credit_i(credit_i), .credits_o(credits0),
        .outstanding_o(outst0), .idle_o(idle0), .err_o(err0)
    );

    prim_fifo_credit_tx #(.Width(8), .Depth(4), .Secure(1'b1)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .valid_i(valid_i),
        .ready_o(ready1), .data_i(data_i), .tx_valid_o(tx_valid1),
        .tx_data_o(tx_data1), .credit_i(credit_i), .credits_o(credits1),
        .outstanding_o(outst1), .idle_o(idle1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks common to both instances.
    task automatic chk_both(input string tag, input logic rdy, input logic txv,
                            input logic [7:0] txd, input logic [2:0] cr,
                            input logic idl, input logic er);
        chk({tag, " s0 ready"},    32'(ready0),    32'(rdy));
        chk({tag, " s0 tx_valid"}, 32'(tx_valid0), 32'(txv));
        chk({tag, " s0 tx_data"},  32'(tx_data0),  32'(txd));
        chk({tag, " s0 credits"},  32'(credits0),  32'(cr));
        chk({tag, " s0 outst"},    32'(outst0),    32'(3'd4 - cr));
        chk({tag, " s0 idle"},     32'(idle0),     32'(idl));
        chk({tag, " s0 err"},      32'(err0),      32'(er));
        chk({tag, " s1 ready"},    32'(ready1),    32'(rdy));
        chk({tag, " s1 tx_valid"}, 32'(tx_valid1), 32'(txv));
        chk({tag, " s1 tx_data"},  32'(tx_data1),  32'(txd));
        chk({tag, " s1 credits"},  32'(credits1),  32'(cr));
        chk({tag, " s1 outst"},    32'(outst1),    32'(3'd4 - cr));
        chk({tag, " s1 idle"},     32'(idle1),     32'(idl));
        chk({tag, " s1 err"},      32'(err1),      32'(er));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [2:0] exp_cr;
        logic [7:0] exp_d;

        rst_ni = 1'b0; clr_i = 1'b0; valid_i = 1'b0; data_i = 8'h00; credit_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        step();
        chk_both("reset", 1'b1, 1'b0, 8'h00, 3'd4, 1'b1, 1'b0);

        // Drain all credits: words 0x10..0x13 go out, 0x14/0x15 stall.
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h10 + 8'(i);
            chk("fill pre s0 ready", 32'(ready0), 32'(i < 4));
            chk("fill pre s1 ready", 32'(ready1), 32'(i < 4));
            step();
            exp_cr = (i < 4) ? 3'(3 - i) : 3'd0;
            exp_d  = (i < 4) ? 8'h10 + 8'(i) : 8'h13;
            chk_both("fill", exp_cr != 3'd0, i < 4, exp_d, exp_cr, 1'b0, 1'b0);
        end

        // One credit returns while starved; held word 0x14 then goes out.
        data_i = 8'h14; credit_i = 1'b1;
        step();
        chk_both("credit in", 1'b1, 1'b0, 8'h13, 3'd1, 1'b0, 1'b0);
        credit_i = 1'b0;
        step();
        chk_both("held send", 1'b0, 1'b1, 8'h14, 3'd0, 1'b0, 1'b0);

        // Build up to two credits, then stream with a credit every cycle.
        valid_i = 1'b0; credit_i = 1'b1;
        step(); step();
        chk_both("to two", 1'b1, 1'b0, 8'h14, 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; data_i = 8'h20 + 8'(i);
            step();
            chk_both("stream", 1'b1, 1'b1, 8'h20 + 8'(i), 3'd2, 1'b0, 1'b0);
        end
        valid_i = 1'b0;
        step();
        chk_both("refill a", 1'b1, 1'b0, 8'h23, 3'd3, 1'b0, 1'b0);
        step();
        chk_both("refill b", 1'b1, 1'b0, 8'h23, 3'd4, 1'b1, 1'b0);

        // Extra credit at full count: saturates and flags the error.
        step();
        chk_both("overflow", 1'b1, 1'b0, 8'h23, 3'd4, 1'b1, 1'b1);
        credit_i = 1'b0;

        // Spend three credits, then clear with send and credit both active.
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; data_i = 8'h30 + 8'(i);
            step();
        end
        chk_both("pre clr", 1'b1, 1'b1, 8'h32, 3'd1, 1'b0, 1'b1);
        clr_i = 1'b1; data_i = 8'h33; credit_i = 1'b1;
        chk("clr s0 ready", 32'(ready0), 32'd1);
        chk("clr s1 ready", 32'(ready1), 32'd1);
        step();
        clr_i = 1'b0; valid_i = 1'b0; credit_i = 1'b0;
        chk_both("clr", 1'b1, 1'b0, 8'h32, 3'd4, 1'b1, 1'b1);
        step();
        chk_both("after clr", 1'b1, 1'b0, 8'h32, 3'd4, 1'b1, 1'b1);

        // Only reset clears the sticky error.
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        chk_both("reset2", 1'b1, 1'b0, 8'h00, 3'd4, 1'b1, 1'b0);

        // Corrupt the hardened counter's shadow copy for one edge.
        force dut1.gen_secure_cnt.u_cnt.r_cnt_inv = 3'b000;
        #1;
        chk("glitch s1 err pre", 32'(err1), 32'd0);
        step();
        release dut1.gen_secure_cnt.u_cnt.r_cnt_inv;
        chk("glitch s1 err", 32'(err1), 32'd1);
        chk("glitch s0 err", 32'(err0), 32'd0);
        step();
        chk("glitch s1 sticky", 32'(err1), 32'd1);
        chk("glitch s1 credits", 32'(credits1), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
